// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU and its operand feeder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   OP_*            3-bit ALU opcode encodings carried on the op bus
//   feeder_state_e  2-bit feeder FSM state encoding
package alu_pkg;

    // ALU opcode encodings. The feeder only transports these; the ALU
    // interprets them.
    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_XOR   = 3'b010;
    localparam logic [2:0] OP_ADD   = 3'b011;
    localparam logic [2:0] OP_SUB   = 3'b100;
    localparam logic [2:0] OP_PASSA = 3'b101;
    localparam logic [2:0] OP_PASSB = 3'b110;
    localparam logic [2:0] OP_NOP   = 3'b111;

    // Feeder FSM: IDLE -> SHIFT -> (DRAIN) -> DONE -> IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } feeder_state_e;

endpackage

// File: rtl/serial_operand_feeder_shift_reg.sv
// WIDTH-bit shift register: parallel load, shift right with serial-in at the MSB.
// Latency: one clock from load/shift_en to par_out.
// Backpressure: none; the owner decides when to load or shift.
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-low reset, clears the register
//   load      parallel load of load_dat (wins over shift_en)
//   load_dat  parallel load value
//   shift_en  shift right one place, ser_in enters at the MSB
//   ser_in    serial input bit
//   par_out   current register contents; par_out[0] is the next bit out
module serial_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_dat,
    input  logic             shift_en,
    input  logic             ser_in,
    output logic [WIDTH-1:0] par_out
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = load_dat;
        end else if (shift_en) begin
            data_d = {ser_in, data_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign par_out = data_q;

endmodule

// File: rtl/serial_operand_feeder.sv
// Feeds a parallel operand pair LSB-first into a bit-serial ALU and reassembles its serial result.
// Latency: accept cycle to first res_valid cycle is WIDTH+ALU_LAT+1 cycles; one transaction per WIDTH+ALU_LAT+2.
// Backpressure: in_ready is low from accept until the result is taken; res_valid holds until res_ready.
//
// Parameters:
//   WIDTH    operand/result width (>= 2)
//   ALU_LAT  cycles from a bit on ain/bin to its aluout bit (0 or 1)
// Ports:
//   reclk                     clock, rising edge
//   rst                       synchronous active-low reset
//   in_valid/in_ready         operand handshake for a_in, b_in, op_in
//   ain, bin, op              serial operand bits and held opcode to the ALU
//   alu_clr                   high on bit 0 only, clears ALU carry/state
//   bit_valid                 ain/bin carry a live bit this cycle
//   aluout                    serial result bit from the ALU
//   result/res_valid/res_ready  parallel result handshake
module serial_operand_feeder
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int ALU_LAT = 1
) (
    input  logic             reclk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [2:0]       op_in,
    output logic             ain,
    output logic             bin,
    output logic [2:0]       op,
    output logic             alu_clr,
    output logic             bit_valid,
    input  logic             aluout,
    output logic [WIDTH-1:0] result,
    output logic             res_valid,
    input  logic             res_ready
);

    localparam int                CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WIDTH - 1);
    // With a registered ALU the last result bit arrives one cycle after the
    // last operand bit, so an extra DRAIN cycle is needed to catch it.
    localparam bit                HAS_DRAIN = (ALU_LAT == 1);

    feeder_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;

    logic             accept;
    logic             shifting;
    logic             capture;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;

    // Upper operand bits only ever leave through bit 0 by shifting.
    logic             unused_sh_bits;
    assign unused_sh_bits = ^{a_sh[WIDTH-1:1], b_sh[WIDTH-1:1]};

    assign accept   = (state_q == ST_IDLE) && in_valid;
    assign shifting = (state_q == ST_SHIFT);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    op_d    = op_in;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    state_d = HAS_DRAIN ? ST_DRAIN : ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge reclk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= 3'b000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from the current state so that they take their
    // reset values on the same edge that reset is sampled.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        res_valid = 1'b0;
        bit_valid = 1'b0;
        alu_clr   = 1'b0;
        ain       = 1'b0;
        bin       = 1'b0;
        unique case (state_q)
            ST_IDLE:  in_ready = 1'b1;
            ST_SHIFT: begin
                bit_valid = 1'b1;
                alu_clr   = (cnt_q == '0);
                ain       = a_sh[0];
                bin       = b_sh[0];
            end
            ST_DONE:  res_valid = 1'b1;
            default:  ;
        endcase
    end

    assign op = op_q;

    // Result bit k is on aluout ALU_LAT cycles after operand bit k. With no
    // latency every SHIFT cycle carries a result bit; with one cycle of
    // latency the slots move to SHIFT bits 1..WIDTH-1 plus DRAIN. Either
    // way exactly WIDTH samples are taken, so stale contents are flushed
    // out and the collector needs no clear on accept.
    always_comb begin
        if (HAS_DRAIN) begin
            capture = (shifting && (cnt_q != '0)) || (state_q == ST_DRAIN);
        end else begin
            capture = shifting;
        end
    end

    // ------------------------------------------------------------------
    // Operand shifters and result collector
    // ------------------------------------------------------------------
    serial_shift_reg #(.WIDTH(WIDTH)) u_a_shifter (
        .clk      (reclk),
        .rst      (rst),
        .load     (accept),
        .load_dat (a_in),
        .shift_en (shifting),
        .ser_in   (1'b0),
        .par_out  (a_sh)
    );

    serial_shift_reg #(.WIDTH(WIDTH)) u_b_shifter (
        .clk      (reclk),
        .rst      (rst),
        .load     (accept),
        .load_dat (b_in),
        .shift_en (shifting),
        .ser_in   (1'b0),
        .par_out  (b_sh)
    );

    // Samples enter at the MSB and move right, so after WIDTH samples the
    // first-captured bit (ALU bit 0) sits at result[0].
    serial_shift_reg #(.WIDTH(WIDTH)) u_res_collector (
        .clk      (reclk),
        .rst      (rst),
        .load     (1'b0),
        .load_dat ({WIDTH{1'b0}}),
        .shift_en (capture),
        .ser_in   (aluout),
        .par_out  (result)
    );

endmodule
